// File: rtl/sync_down_counter_nbit.sv
// Loadable N-bit down counter with one-shot and auto-reload modes.
// Used as the timeout / interval timer in the sequential block set.
module sync_down_counter_nbit #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         mode,
   output logic [N-1:0] Q,
   output logic         tc,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [N-1:0] reload, reload_nxt;
   logic [N-1:0] q_nxt;
   logic         tc_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         reload <= '0;
         Q      <= '0;
         tc     <= 1'b0;
      end else begin
         state  <= state_nxt;
         reload <= reload_nxt;
         Q      <= q_nxt;
         tc     <= tc_nxt;
      end
   end

   // Expiry is detected at Q==1 so the count never wraps below zero.
   always_comb begin
      state_nxt  = state;
      reload_nxt = reload;
      q_nxt      = Q;
      tc_nxt     = 1'b0;
      if (load) begin
         q_nxt      = load_val;
         reload_nxt = load_val;
         state_nxt  = (load_val != '0) ? RUN : DONE;
      end else if (state == RUN && en) begin
         if (Q == N'(1)) begin
            tc_nxt = 1'b1;
            if (mode) begin
               q_nxt = reload;
            end else begin
               q_nxt     = '0;
               state_nxt = DONE;
            end
         end else begin
            q_nxt = Q - N'(1);
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_sync_down_counter_nbit.sv
// Randomized and directed bench for sync_down_counter_nbit against a
// period-based reference model (enabled cycles elapsed since the last load).
module tb_sync_down_counter_nbit;

   localparam int N = 8;

   logic         clk;
   logic         rst;
   logic         en;
   logic         load;
   logic [N-1:0] load_val;
   logic         mode;
   logic [N-1:0] Q;
   logic         tc;
   logic         busy;
   logic         done;

   int checks = 0;
   int passed = 0;

   int lval     = 0;
   int elapsed  = 0;
   bit running  = 0;
   bit finished = 0;
   bit exp_tc   = 0;

   sync_down_counter_nbit #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .mode     (mode),
      .Q        (Q),
      .tc       (tc),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      else
         passed++;
   endtask

   function automatic int expQ();
      return running ? (lval - elapsed) : 0;
   endfunction

   task automatic checkModel();
      checkOutput("q", 32'(Q), 32'(expQ()));
      checkOutput("tc", 32'(tc), 32'(exp_tc));
      checkOutput("busy", 32'(busy), 32'(running));
      checkOutput("done", 32'(done), 32'(finished));
   endtask

   task automatic modelReset();
      lval     = 0;
      elapsed  = 0;
      running  = 0;
      finished = 0;
      exp_tc   = 0;
   endtask

   // The count is L minus enabled cycles since the period began; a period ends when L are consumed.
   task automatic modelStep(input bit l, input int lv, input bit e, input bit m);
      exp_tc = 0;
      if (l) begin
         lval     = lv;
         elapsed  = 0;
         running  = (lv != 0);
         finished = (lv == 0);
      end else if (running && e) begin
         elapsed++;
         if (elapsed == lval) begin
            exp_tc = 1;
            if (m) begin
               elapsed = 0;
            end else begin
               running  = 0;
               finished = 1;
            end
         end
      end
   endtask

   task automatic applyStimulus(input bit l, input logic [N-1:0] lv, input bit e, input bit m);
      @(negedge clk);
      load     = l;
      load_val = lv;
      en       = e;
      mode     = m;
      @(posedge clk);
      modelStep(l, int'(lv), e, m);
      #1;
      checkModel();
   endtask

   task automatic asyncReset();
      @(negedge clk);
      load = 1'b0;
      en   = 1'b0;
      #1 rst = 1'b0;
      modelReset();
      #1;
      checkModel();
      #1 rst = 1'b1;
   endtask

   initial begin
      int cycles;
      rst      = 1'b0;
      en       = 1'b0;
      load     = 1'b0;
      load_val = '0;
      mode     = 1'b0;
      modelReset();
      #2;
      checkModel();
      #10 rst = 1'b1;

      applyStimulus(1, 8'd5, 0, 0);
      checkOutput("q_after_load5", 32'(Q), 32'd5);
      for (int i = 0; i < 8; i++) applyStimulus(0, 8'd0, 1, 0);
      checkOutput("oneshot_done", 32'(done), 32'd1);

      applyStimulus(1, 8'd3, 0, 1);
      for (int i = 0; i < 7; i++) applyStimulus(0, 8'd0, 1, 1);
      applyStimulus(0, 8'd0, 0, 1);
      applyStimulus(0, 8'd0, 0, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 8'd0, 1, 1);

      applyStimulus(1, 8'd2, 0, 0);
      applyStimulus(0, 8'd0, 1, 0);
      checkOutput("q_at_one", 32'(Q), 32'd1);
      applyStimulus(1, 8'd9, 1, 0);
      checkOutput("load_priority_q", 32'(Q), 32'd9);
      checkOutput("load_priority_tc", 32'(tc), 32'd0);

      applyStimulus(1, 8'd0, 1, 0);
      checkOutput("load_zero_done", 32'(done), 32'd1);
      applyStimulus(0, 8'd0, 1, 0);

      applyStimulus(1, 8'hFF, 0, 0);
      cycles = 0;
      while (tc !== 1'b1 && cycles < 300) begin
         applyStimulus(0, 8'd0, 1, 0);
         cycles++;
      end
      checkOutput("ff_period", 32'(cycles), 32'd255);

      applyStimulus(1, 8'd10, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 8'd0, 1, 0);
      checkOutput("q_before_reset", 32'(Q), 32'd7);
      asyncReset();
      for (int i = 0; i < 4; i++) applyStimulus(0, 8'd0, 1, 0);
      checkOutput("q_after_reset", 32'(Q), 32'd0);

      for (int i = 0; i < 600; i++) begin
         bit          l;
         logic [N-1:0] lv;
         l  = ($urandom_range(0, 15) == 0);
         lv = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'($urandom_range(0, 12));
         if ($urandom_range(0, 99) == 0)
            asyncReset();
         applyStimulus(l, lv, ($urandom_range(0, 3) != 0), 1'($urandom));
      end

      $display("[TB] %0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
